// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared types and constants for the fetch PC sequencer and its redirect arbiter.
package fetch_pc_sequencer_pkg;

   localparam int DEF_WIDTH      = 32;
   localparam int DEF_NUM_SRC    = 4;
   localparam int DEF_EPOCH_BITS = 3;

   // Redirect channel indices, highest priority first; SRC_SEQ tags sequential/predictor PCs.
   localparam int SRC_ROB       = 0;
   localparam int SRC_MISDIRECT = 1;
   localparam int SRC_JAL       = 2;
   localparam int SRC_SEQ       = DEF_NUM_SRC;

   typedef logic [DEF_WIDTH-1:0]              pc_t;
   typedef logic [$clog2(DEF_NUM_SRC+1)-1:0]  src_idx_t;
   typedef logic [DEF_EPOCH_BITS-1:0]         epoch_t;

   // Width of a source index able to hold every channel plus the sequential tag.
   function automatic int src_idx_width(input int num_src);
      return $clog2(num_src + 1);
   endfunction

endpackage

// File: rtl/fetch_pc_sequencer_redirect_priority_arbiter.sv
// Combinational lowest-index-first select across the redirect channels.
module redirect_priority_arbiter
   import fetch_pc_sequencer_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NUM_SRC = DEF_NUM_SRC,
   parameter int SRC_W   = src_idx_width(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0]            valid,
   input  logic [NUM_SRC-1:0][WIDTH-1:0] target,
   input  logic [NUM_SRC-1:0]            flush,
   output logic                          winnerValid,
   output logic [SRC_W-1:0]              winnerIdx,
   output logic [WIDTH-1:0]              winnerTarget,
   output logic                          winnerFlush
);

   // Scan from the lowest-priority channel upward so the lowest valid index is the last write.
   always_comb begin
      winnerValid  = 1'b0;
      winnerIdx    = SRC_W'(NUM_SRC);
      winnerTarget = '0;
      winnerFlush  = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (valid[i]) begin
            winnerValid  = 1'b1;
            winnerIdx    = SRC_W'(i);
            winnerTarget = target[i];
            winnerFlush  = flush[i];
         end
      end
   end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Next fetch PC generator: redirects, predictor or sequential PC, with held
// redirects across freeze, a flush epoch counter and per-PC provenance.
module fetch_pc_sequencer
   import fetch_pc_sequencer_pkg::*;
#(
   parameter int               WIDTH       = DEF_WIDTH,
   parameter int               NUM_SRC     = DEF_NUM_SRC,
   parameter int               FETCH_WIDTH = 1,
   parameter int               EPOCH_BITS  = DEF_EPOCH_BITS,
   parameter logic [WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                                  clk,
   input  logic                                  globalResetN,
   input  logic                                  freeze,
   input  logic [NUM_SRC-1:0]                    redirectValid,
   input  logic [NUM_SRC-1:0][WIDTH-1:0]         redirectTarget,
   input  logic [NUM_SRC-1:0]                    redirectFlush,
   input  logic                                  predictorHit,
   input  logic [WIDTH-1:0]                      predictedPC,
   output logic [WIDTH-1:0]                      fetchPC,
   output logic                                  predRedirect,
   output logic [$clog2(NUM_SRC+1)-1:0]          redirectSrc,
   output logic [EPOCH_BITS-1:0]                 epoch,
   output logic                                  pendingValid
);

   localparam int SRC_W = src_idx_width(NUM_SRC);
   localparam logic [SRC_W-1:0] SEQ_IDX = SRC_W'(NUM_SRC);

   logic                  winner_valid;
   logic [SRC_W-1:0]      winner_idx;
   logic [WIDTH-1:0]      winner_target;
   logic                  winner_flush;

   logic [WIDTH-1:0]      pc_q;
   logic                  pred_q;
   logic [SRC_W-1:0]      src_q;
   logic [EPOCH_BITS-1:0] epoch_q;
   logic                  pend_valid;
   logic [SRC_W-1:0]      pend_idx;
   logic [WIDTH-1:0]      pend_target;

   logic                  accept;
   logic                  bump;
   logic [WIDTH-1:0]      next_pc;
   logic                  next_pred;
   logic [SRC_W-1:0]      next_src;

   redirect_priority_arbiter #(
      .WIDTH   (WIDTH),
      .NUM_SRC (NUM_SRC),
      .SRC_W   (SRC_W)
   ) u_arbiter (
      .valid        (redirectValid),
      .target       (redirectTarget),
      .flush        (redirectFlush),
      .winnerValid  (winner_valid),
      .winnerIdx    (winner_idx),
      .winnerTarget (winner_target),
      .winnerFlush  (winner_flush)
   );

   // A winner is taken (applied or held) unless a higher-priority redirect is already held.
   always_comb begin
      accept = winner_valid && (!pend_valid || (winner_idx <= pend_idx));
      bump   = accept && winner_flush;
   end

   // Unfrozen next-PC choice: accepted winner, then held redirect, then predictor, then sequential.
   always_comb begin
      next_pc   = pc_q + WIDTH'(FETCH_WIDTH);
      next_pred = 1'b0;
      next_src  = SEQ_IDX;
      if (accept) begin
         next_pc  = winner_target;
         next_src = winner_idx;
      end else if (pend_valid) begin
         next_pc  = pend_target;
         next_src = pend_idx;
      end else if (predictorHit) begin
         next_pc   = predictedPC;
         next_pred = 1'b1;
      end
   end

   // Fetch PC, provenance, held redirect and epoch state; freeze holds the PC and captures redirects.
   always_ff @(posedge clk or negedge globalResetN) begin
      if (!globalResetN) begin
         pc_q        <= RESET_PC;
         pred_q      <= 1'b0;
         src_q       <= SEQ_IDX;
         epoch_q     <= '0;
         pend_valid  <= 1'b0;
         pend_idx    <= SEQ_IDX;
         pend_target <= '0;
      end else begin
         if (bump) begin
            epoch_q <= epoch_q + 1'b1;
         end
         if (freeze) begin
            if (accept) begin
               pend_valid  <= 1'b1;
               pend_idx    <= winner_idx;
               pend_target <= winner_target;
            end
         end else begin
            pc_q       <= next_pc;
            pred_q     <= next_pred;
            src_q      <= next_src;
            pend_valid <= 1'b0;
         end
      end
   end

   assign fetchPC      = pc_q;
   assign predRedirect = pred_q;
   assign redirectSrc  = src_q;
   assign epoch        = epoch_q;
   assign pendingValid = pend_valid;

endmodule
